// File: rtl/audio_pkg.sv
// Shared sizing constants and the loader state type for the audio frame loader.
package audio_pkg;

    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned SAMPLES_PER_LINE = 32;
    localparam int unsigned LINES_PER_FRAME  = 64;
    localparam int unsigned BUS_W            = SAMPLE_W * SAMPLES_PER_LINE;
    localparam int unsigned IDX_W            = $clog2(LINES_PER_FRAME);
    localparam int unsigned SLOT_W           = $clog2(SAMPLES_PER_LINE);
    localparam int unsigned FC_W             = 16;

    typedef enum logic [1:0] {
        FILL,
        FLUSH,
        START,
        WAIT_DONE
    } loader_state_t;

endpackage

// File: rtl/audio_line_packer.sv
// Assembles up to SAMPLES_PER_LINE samples into one bus line, sample 0 in the LSBs.
module audio_line_packer
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accept,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                clear,
    input  logic                pad_zero,
    output logic [BUS_W-1:0]    line_c,
    output logic                line_full_c,
    output logic [SLOT_W-1:0]   slot_cnt
);

    logic [BUS_W-1:0] asm_q;

    // Line as it stands including a sample accepted this cycle; unfilled lanes are already zero.
    always_comb begin
        line_c = asm_q;
        if (accept) begin
            line_c[32'(slot_cnt) * SAMPLE_W +: SAMPLE_W] = sample;
        end
        if (pad_zero) begin
            line_c = '0;
        end
    end

    assign line_full_c = accept && (slot_cnt == SLOT_W'(SAMPLES_PER_LINE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q    <= '0;
            slot_cnt <= '0;
        end else if (clear) begin
            asm_q    <= '0;
            slot_cnt <= '0;
        end else if (accept) begin
            asm_q    <= line_c;
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/audio_frame_loader.sv
// Packs a PCM sample stream into 512-bit lines, loads a 64-line frame into
// AudioProcessor, starts it and waits for done before taking the next frame.
module audio_frame_loader
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                flush,
    output logic                proc_data_wr_en,
    output logic [IDX_W-1:0]    proc_input_index,
    output logic [BUS_W-1:0]    proc_data_in,
    output logic                proc_start,
    input  logic                proc_done,
    output logic                busy,
    output logic [FC_W-1:0]     frame_count
);

    loader_state_t     state;
    logic [IDX_W-1:0]  line_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic [BUS_W-1:0]  line_c;
    logic              line_full_c;
    logic              accept_c;
    logic              flush_go_c;
    logic              commit_c;
    logic              last_line_c;

    assign accept_c    = sample_valid && sample_ready;
    // A flush only counts once the frame holds at least one sample, including one taken this cycle.
    assign flush_go_c  = (state == FILL) && flush &&
                         (accept_c || (slot_cnt != '0) || (line_cnt != '0));
    assign commit_c    = (state == FLUSH) || ((state == FILL) && (line_full_c || flush_go_c));
    assign last_line_c = (line_cnt == IDX_W'(LINES_PER_FRAME - 1));

    audio_line_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept      (accept_c),
        .sample      (sample_in),
        .clear       (commit_c),
        .pad_zero    (state == FLUSH),
        .line_c      (line_c),
        .line_full_c (line_full_c),
        .slot_cnt    (slot_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= FILL;
            line_cnt         <= '0;
            sample_ready     <= 1'b0;
            proc_data_wr_en  <= 1'b0;
            proc_input_index <= '0;
            proc_data_in     <= '0;
            proc_start       <= 1'b0;
            busy             <= 1'b0;
            frame_count      <= '0;
        end else begin
            proc_data_wr_en <= 1'b0;
            proc_start      <= 1'b0;

            // Line write shared by full-line, flush and zero-fill cycles.
            if (commit_c) begin
                proc_data_wr_en  <= 1'b1;
                proc_input_index <= line_cnt;
                proc_data_in     <= line_c;
                line_cnt         <= line_cnt + IDX_W'(1);
            end

            unique case (state)
                FILL: begin
                    sample_ready <= 1'b1;
                    if (commit_c && last_line_c) begin
                        sample_ready <= 1'b0;
                        state        <= START;
                    end else if (flush_go_c) begin
                        sample_ready <= 1'b0;
                        state        <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (last_line_c) begin
                        state <= START;
                    end
                end
                START: begin
                    proc_start <= 1'b1;
                    busy       <= 1'b1;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (proc_done) begin
                        frame_count  <= frame_count + FC_W'(1);
                        busy         <= 1'b0;
                        sample_ready <= 1'b1;
                        line_cnt     <= '0;
                        state        <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_loader.sv
// Bench for audio_frame_loader: frame-level reference model checked every cycle plus literal pins.
module tb_audio_frame_loader;
    import audio_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  sample_in;
    logic         sample_valid;
    logic         sample_ready;
    logic         flush;
    logic         proc_data_wr_en;
    logic [5:0]   proc_input_index;
    logic [511:0] proc_data_in;
    logic         proc_start;
    logic         proc_done;
    logic         busy;
    logic [15:0]  frame_count;

    always #5 clk = ~clk;

    audio_frame_loader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .flush            (flush),
        .proc_data_wr_en  (proc_data_wr_en),
        .proc_input_index (proc_input_index),
        .proc_data_in     (proc_data_in),
        .proc_start       (proc_start),
        .proc_done        (proc_done),
        .busy             (busy),
        .frame_count      (frame_count)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit           m_open;
    int           m_cnt;
    logic [15:0]  m_smp [2048];
    bit           m_fl;
    int           m_fl_next;
    bit           m_start_next;
    bit           m_wait;
    logic         e_ready, e_wr, e_start, e_busy;
    logic [5:0]   e_idx;
    logic [511:0] e_data;
    logic [15:0]  e_fc;

    function automatic logic [511:0] m_pack(input int line);
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 32; k++)
            if (line * 32 + k < m_cnt) v[k*16 +: 16] = m_smp[line*32 + k];
        return v;
    endfunction

    task automatic m_emit(input int line);
        e_wr   = 1'b1;
        e_idx  = 6'(line);
        e_data = m_pack(line);
    endtask

    task automatic m_reset();
        m_open = 1; m_cnt = 0; m_fl = 0; m_fl_next = 0; m_start_next = 0; m_wait = 0;
        e_ready = 0; e_wr = 0; e_start = 0; e_busy = 0; e_idx = '0; e_data = '0; e_fc = '0;
    endtask

    // Advance the model by one clock edge using pre-edge inputs.
    task automatic m_step();
        bit acc;
        int em;
        acc     = sample_valid && e_ready;
        e_wr    = 1'b0;
        e_start = 1'b0;
        if (acc && m_cnt < 2048) begin
            m_smp[m_cnt] = sample_in;
            m_cnt++;
        end
        if (m_open) begin
            em = -1;
            if (acc && (m_cnt % 32 == 0)) begin
                em = m_cnt / 32 - 1;
                m_emit(em);
            end
            if (flush && m_cnt > 0 && em != 63) begin
                if (em < 0) begin
                    em = m_cnt / 32;
                    m_emit(em);
                end
                m_open = 0;
                if (em == 63) m_start_next = 1;
                else begin
                    m_fl = 1;
                    m_fl_next = em + 1;
                end
            end else if (em == 63) begin
                m_open = 0;
                m_start_next = 1;
            end
            e_ready = m_open;
        end else if (m_fl) begin
            m_emit(m_fl_next);
            if (m_fl_next == 63) begin
                m_fl = 0;
                m_start_next = 1;
            end
            m_fl_next++;
        end else if (m_start_next) begin
            m_start_next = 0;
            e_start = 1'b1;
            e_busy  = 1'b1;
            m_wait  = 1;
        end else if (m_wait && proc_done) begin
            m_wait  = 0;
            e_busy  = 1'b0;
            e_fc    = e_fc + 16'd1;
            e_ready = 1'b1;
            m_open  = 1;
            m_cnt   = 0;
        end
    endtask

    // ---------------- capture of DUT writes ----------------
    logic [511:0] cap_data [64];
    int           cap_idx  [64];
    int           cap_cyc  [64];
    int           wr_total;
    int           start_n;
    int           start_cyc;

    task automatic cap_clear();
        wr_total = 0;
        start_n  = 0;
        start_cyc = -1;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        m_reset();
        cap_clear();
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n === 1'b1) m_step();
            @(negedge clk);
            if (rst_n !== 1'b1) m_reset();
            chk("sample_ready", 512'(sample_ready), 512'(e_ready));
            chk("proc_data_wr_en", 512'(proc_data_wr_en), 512'(e_wr));
            chk("proc_input_index", 512'(proc_input_index), 512'(e_idx));
            chk("proc_data_in", proc_data_in, e_data);
            chk("proc_start", 512'(proc_start), 512'(e_start));
            chk("busy", 512'(busy), 512'(e_busy));
            chk("frame_count", 512'(frame_count), 512'(e_fc));
            chk("wr_start_overlap", 512'(proc_data_wr_en & proc_start), 512'(0));
            if (proc_data_wr_en) begin
                if (wr_total < 64) begin
                    cap_data[wr_total] = proc_data_in;
                    cap_idx[wr_total]  = int'(proc_input_index);
                    cap_cyc[wr_total]  = cyc;
                end
                wr_total++;
            end
            if (proc_start) begin
                start_n++;
                start_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    int nxt;

    task automatic send(input int n, input int duty, input int budget);
        int got;
        int c;
        got = 0;
        c = 0;
        while (got < n && c < budget) begin
            sample_valid = ($urandom_range(99) < duty);
            sample_in    = 16'(nxt);
            @(posedge clk);
            if (sample_valid && sample_ready) begin
                got++;
                nxt++;
            end
            #1;
            c++;
        end
        sample_valid = 1'b0;
        vectors++;
        if (got < n) begin
            errors++;
            $display("FAIL send: accepted %0d of %0d samples within %0d cycles", got, n, budget);
        end
    endtask

    task automatic wait_start(input int budget);
        int c;
        int s0;
        c = 0;
        s0 = start_n;
        while (start_n == s0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        vectors++;
        if (start_n == s0) begin
            errors++;
            $display("FAIL wait_start: no proc_start within %0d cycles", budget);
        end
    endtask

    task automatic pulse(input bit is_done);
        if (is_done) proc_done = 1'b1; else flush = 1'b1;
        @(posedge clk);
        #1;
        proc_done = 1'b0;
        flush = 1'b0;
    endtask

    // Literal pins for a frame whose sample k has value k.
    task automatic check_seq_frame(input string tag, input bit spaced);
        logic [511:0] v;
        chk({tag, "_writes"}, 512'(wr_total), 512'(64));
        for (int j = 0; j < 64; j++) begin
            v = cap_data[j];
            chk($sformatf("%s_l%0d_index", tag, j), 512'(cap_idx[j]), 512'(j));
            chk($sformatf("%s_l%0d_lane0", tag, j), 512'(v[15:0]), 512'(32 * j));
            chk($sformatf("%s_l%0d_lane31", tag, j), 512'(v[511:496]), 512'(32 * j + 31));
            if (spaced && j > 0)
                chk($sformatf("%s_l%0d_spacing", tag, j), 512'(cap_cyc[j] - cap_cyc[j-1]), 512'(32));
        end
        v = cap_data[0];
        chk({tag, "_l0_lane1"}, 512'(v[31:16]), 512'(1));
        chk({tag, "_start_count"}, 512'(start_n), 512'(1));
        chk({tag, "_start_after_last"}, 512'(start_cyc - cap_cyc[63]), 512'(1));
    endtask

    initial begin
        logic [511:0] v;
        rst_n = 1'b0; sample_valid = 1'b1; sample_in = 16'h1234;
        flush = 1'b0; proc_done = 1'b0; nxt = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_ready", 512'(sample_ready), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_data", proc_data_in, 512'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_first_edge", 512'(sample_ready), 512'(1));

        // Continuous full frame
        cap_clear();
        send(2048, 100, 3000);
        wait_start(10);
        check_seq_frame("cont", 1'b1);
        chk("busy_after_start", 512'(busy), 512'(1));

        // Long done wait, with a flush that must be ignored
        repeat (50) @(posedge clk);
        #1;
        pulse(1'b0);
        repeat (50) @(posedge clk);
        #1;
        chk("wait_ready", 512'(sample_ready), 512'(0));
        chk("wait_busy", 512'(busy), 512'(1));
        pulse(1'b1);
        chk("done_frame_count", 512'(frame_count), 512'(1));
        chk("done_ready", 512'(sample_ready), 512'(1));
        chk("done_busy", 512'(busy), 512'(0));

        // Flush after 40 samples, preceded by a flush on an empty frame
        cap_clear();
        pulse(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("empty_flush_writes", 512'(wr_total), 512'(0));
        nxt = 0;
        send(40, 100, 200);
        pulse(1'b0);
        wait_start(100);
        chk("fl_writes", 512'(wr_total), 512'(64));
        chk("fl_first_index", 512'(cap_idx[0]), 512'(0));
        v = cap_data[0];
        chk("fl_l0_lane31", 512'(v[511:496]), 512'(31));
        v = cap_data[1];
        chk("fl_l1_lane0", 512'(v[15:0]), 512'(32));
        chk("fl_l1_lane7", 512'(v[127:112]), 512'(39));
        chk("fl_l1_upper_zero", 512'(v[511:128]), 512'(0));
        for (int j = 2; j < 64; j++) begin
            chk($sformatf("fl_l%0d_zero", j), cap_data[j], 512'(0));
            chk($sformatf("fl_l%0d_consec", j), 512'(cap_cyc[j] - cap_cyc[j-1]), 512'(1));
        end
        chk("fl_start_after_last", 512'(start_cyc - cap_cyc[63]), 512'(1));
        pulse(1'b1);
        chk("fl_frame_count", 512'(frame_count), 512'(2));

        // Gapped traffic at roughly 30% valid duty
        cap_clear();
        nxt = 0;
        send(2048, 30, 20000);
        wait_start(10);
        check_seq_frame("gap", 1'b0);
        pulse(1'b1);

        // Reset in the middle of a frame, then a fresh frame
        nxt = 0;
        send(1000, 100, 2000);
        rst_n = 1'b0;
        cap_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_frame_count", 512'(frame_count), 512'(0));
        chk("midrst_ready", 512'(sample_ready), 512'(0));
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_write", 512'(wr_total), 512'(0));
        chk("midrst_no_start", 512'(start_n), 512'(0));
        cap_clear();
        nxt = 0;
        send(2048, 100, 3000);
        wait_start(10);
        check_seq_frame("post_rst", 1'b1);
        pulse(1'b1);
        chk("post_rst_frame_count", 512'(frame_count), 512'(1));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
